iob_mbus_arbiter: RTL

Parametrised N-master to 1-slave arbiter for the IOb native bus, successor to the fixed two-port CPU/accelerator bus controller in the full-system wrapper. It grants one master per request, passes the request combinationally to the memory wrapper (cache + RAM), and tracks outstanding reads in an in-order ID FIFO so each `s_rvalid_i` response reaches the master that issued it. It also counts outstanding reads and flags protocol errors, replacing the simulation-only checker in the wrapper with synthesizable logic.

---
 rtl/iob_mbus_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/iob_mbus_arbiter.sv
// iob_mbus_arbiter: N-master to 1-slave IOb native bus arbiter with in-order read-response routing.
// Define IOB_MBUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module iob_mbus_arbiter #(
    parameter int unsigned N_MASTERS       = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                 clk_i,
    input  logic                                 arst_n_i,
    input  logic [N_MASTERS-1:0]                 m_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]          m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]          m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]        m_wstrb_i,
    output logic [N_MASTERS-1:0]                 m_ready_o,
    output logic [N_MASTERS-1:0]                 m_rvalid_o,
    output logic [DATA_W-1:0]                    m_rdata_o,
    output logic                                 s_valid_o,
    output logic [ADDR_W-1:0]                    s_addr_o,
    output logic [DATA_W-1:0]                    s_wdata_o,
    output logic [DATA_W/8-1:0]                  s_wstrb_o,
    input  logic                                 s_ready_i,
    input  logic                                 s_rvalid_i,
    input  logic [DATA_W-1:0]                    s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);
    localparam int unsigned STRB_W = DATA_W/8;
    localparam int unsigned ID_W   = $clog2(N_MASTERS);
    localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING+1);
    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_MASTERS-1);
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_OUTSTANDING-1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_OUTSTANDING);

    logic [N_MASTERS-1:0] w_is_wr;
    logic [N_MASTERS-1:0] w_elig;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_found;
    logic                 w_hs;
    logic                 w_push;
    logic                 w_pop;
    logic [ID_W-1:0]      w_win;
    logic [ID_W-1:0]      w_head;
    logic [ID_W-1:0]      w_start;

    logic                 r_lock_vld;
    logic [ID_W-1:0]      r_lock_id;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;
    logic [ID_W-1:0]      r_fifo [MAX_OUTSTANDING];

    // Fullness uses the registered count only, so a same-cycle pop never unblocks a read.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    always_comb begin
        w_is_wr = '0;
        w_elig  = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            w_is_wr[k] = |m_wstrb_i[k*STRB_W +: STRB_W];
            w_elig[k]  = m_valid_i[k] && (w_is_wr[k] || !w_full);
        end
    end

`ifdef IOB_MBUS_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= (w_win == LAST_ID) ? '0 : w_win + 1'b1;
        end
    end

    assign w_start = r_ptr;
`endif

    // A stalled request keeps its master as winner until it handshakes or drops valid.
    always_comb begin
        int unsigned v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_win   = '0;
        if (r_lock_vld) begin
            w_win   = r_lock_id;
            w_found = w_elig[r_lock_id];
        end else begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                v_idx = w_start + i;
                if (v_idx >= N_MASTERS) begin
                    v_idx = v_idx - N_MASTERS;
                end
                if (!w_found && w_elig[v_idx]) begin
                    w_found = 1'b1;
                    w_win   = v_idx[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        s_valid_o = w_found && arst_n_i;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        m_ready_o = '0;
        if (w_found) begin
            s_addr_o         = m_addr_i[w_win*ADDR_W +: ADDR_W];
            s_wdata_o        = m_wdata_i[w_win*DATA_W +: DATA_W];
            s_wstrb_o        = m_wstrb_i[w_win*STRB_W +: STRB_W];
            m_ready_o[w_win] = s_ready_i && arst_n_i;
        end
    end

    assign w_hs   = w_found && s_ready_i;
    assign w_push = w_hs && (s_wstrb_o == '0);
    assign w_pop  = s_rvalid_i && !w_empty;
    assign w_head = r_fifo[r_rd_ptr];

    always_comb begin
        m_rvalid_o = '0;
        if (w_pop && arst_n_i) begin
            m_rvalid_o[w_head] = 1'b1;
        end
    end

    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_lock_vld <= w_found && !s_ready_i;
            r_lock_id  <= w_win;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if ((s_rvalid_i && w_empty) || (r_lock_vld && !m_valid_i[r_lock_id])) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_win;
        end
    end

endmodule
